// File: rtl/md5_pkg.sv
// Shared MD5 constants: padder FSM states, padding/length layout, IV and round constants.
// Pure declarations, no logic.
package md5_pkg;

   typedef enum logic [1:0] {
      S_FILL,
      S_PAD,
      S_LEN,
      S_EMIT
   } state_e;

   localparam logic [7:0] PAD_BYTE      = 8'h80;
   localparam int         LEN_LO_IDX    = 14;
   localparam int         LEN_HI_IDX    = 15;
   localparam logic [5:0] LAST_DATA_IDX = 6'd55;

   localparam logic [31:0] IV_A = 32'h67452301;
   localparam logic [31:0] IV_B = 32'hefcdab89;
   localparam logic [31:0] IV_C = 32'h98badcfe;
   localparam logic [31:0] IV_D = 32'h10325476;

   localparam logic [31:0] K_TABLE [64] = '{
      32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
      32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
      32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
      32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
      32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
      32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
      32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
      32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
      32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
      32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
      32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
      32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
      32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
      32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
      32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
      32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
   };

endpackage

// File: rtl/md5_blk_buf.sv
// 64-byte block register with byte-lane, pad-tail, length and clear writes; 1-cycle write latency.
// No handshake: the owning FSM decides when each write port fires.
module md5_blk_buf
   import md5_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         wr_en_i,
   input  logic [5:0]   idx_i,
   input  logic [7:0]   wr_dat_i,
   input  logic         pad_en_i,
   input  logic         len_en_i,
   input  logic [63:0]  len_i,
   input  logic         clr_i,
   output logic [511:0] blk_o
);

   logic [7:0] byte_q [64];
   logic [7:0] byte_d [64];

   // Write priority: clear, then byte lane, then pad tail, then length words.
   always_comb begin
      for (int k = 0; k < 64; k++) begin
         byte_d[k] = clr_i ? 8'h00 : byte_q[k];
         if (wr_en_i && (idx_i == 6'(k)))
            byte_d[k] = wr_dat_i;
         if (pad_en_i) begin
            if (6'(k) == idx_i)
               byte_d[k] = PAD_BYTE;
            else if (6'(k) > idx_i)
               byte_d[k] = 8'h00;
         end
      end
      if (len_en_i) begin
         for (int j = 0; j < 4; j++) begin
            byte_d[4*LEN_LO_IDX + j] = len_i[8*j +: 8];
            byte_d[4*LEN_HI_IDX + j] = len_i[32 + 8*j +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int k = 0; k < 64; k++)
            byte_q[k] <= 8'h00;
      end else begin
         for (int k = 0; k < 64; k++)
            byte_q[k] <= byte_d[k];
      end
   end

   always_comb begin
      blk_o = '0;
      for (int k = 0; k < 64; k++)
         blk_o[8*k +: 8] = byte_q[k];
   end

endmodule

// File: rtl/md5_padder.sv
// Byte-stream to padded 512-bit MD5 blocks; final block valid 2 cycles after last byte, full block 1 cycle.
// in_ready_o is low while a block is emitted or padded; blk_o is held until blk_ready_i.
module md5_padder
   import md5_pkg::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = 61
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [7:0]      in_data_i,
   input  logic            in_valid_i,
   input  logic            in_last_i,
   output logic            in_ready_o,
   output logic [16*W-1:0] blk_o,
   output logic            blk_valid_o,
   output logic            blk_last_o,
   input  logic            blk_ready_i
);

   if (W != 32) begin : g_w_chk
      $error("md5_padder: only W=32 is supported");
   end
   if (CNT_W > 61 || CNT_W < 1) begin : g_cnt_chk
      $error("md5_padder: CNT_W must be 1..61");
   end

   state_e           state_q, state_d;
   logic [5:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             blk_last_q, blk_last_d;
   logic             blk_valid_q, blk_valid_d;
   logic             pad_pend_q, pad_pend_d;
   logic             len_pend_q, len_pend_d;

   logic             buf_wr, buf_pad, buf_len, buf_clr;
   logic [63:0]      len_w;

   always_comb begin
      len_w = '0;
      len_w[CNT_W+2:0] = {cnt_q, 3'b000};
   end

   assign in_ready_o = (state_q == S_FILL);

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      blk_last_d = blk_last_q;
      pad_pend_d = pad_pend_q;
      len_pend_d = len_pend_q;
      buf_wr     = 1'b0;
      buf_pad    = 1'b0;
      buf_len    = 1'b0;
      buf_clr    = 1'b0;
      unique case (state_q)
         S_FILL: begin
            if (in_valid_i) begin
               buf_wr = 1'b1;
               idx_d  = idx_q + 6'd1;
               cnt_d  = cnt_q + CNT_W'(1);
               if (idx_q == 6'd63) begin
                  state_d    = S_EMIT;
                  blk_last_d = 1'b0;
                  pad_pend_d = in_last_i;
               end else if (in_last_i) begin
                  state_d = S_PAD;
               end
            end
         end
         S_PAD: begin
            buf_pad = 1'b1;
            state_d = S_EMIT;
            // Length only fits if the 0x80 landed before the length words.
            if (idx_q <= LAST_DATA_IDX) begin
               buf_len    = 1'b1;
               blk_last_d = 1'b1;
            end else begin
               blk_last_d = 1'b0;
               len_pend_d = 1'b1;
            end
         end
         S_LEN: begin
            buf_clr    = 1'b1;
            buf_len    = 1'b1;
            len_pend_d = 1'b0;
            blk_last_d = 1'b1;
            state_d    = S_EMIT;
         end
         S_EMIT: begin
            if (blk_ready_i) begin
               if (pad_pend_q) begin
                  buf_clr    = 1'b1;
                  idx_d      = 6'd0;
                  pad_pend_d = 1'b0;
                  state_d    = S_PAD;
               end else if (len_pend_q) begin
                  state_d = S_LEN;
               end else if (blk_last_q) begin
                  buf_clr    = 1'b1;
                  idx_d      = 6'd0;
                  cnt_d      = '0;
                  blk_last_d = 1'b0;
                  state_d    = S_FILL;
               end else begin
                  buf_clr = 1'b1;
                  idx_d   = 6'd0;
                  state_d = S_FILL;
               end
            end
         end
         default: state_d = S_FILL;
      endcase
      blk_valid_d = (state_d == S_EMIT);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_FILL;
         idx_q       <= 6'd0;
         cnt_q       <= '0;
         blk_last_q  <= 1'b0;
         blk_valid_q <= 1'b0;
         pad_pend_q  <= 1'b0;
         len_pend_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         blk_last_q  <= blk_last_d;
         blk_valid_q <= blk_valid_d;
         pad_pend_q  <= pad_pend_d;
         len_pend_q  <= len_pend_d;
      end
   end

   assign blk_valid_o = blk_valid_q;
   assign blk_last_o  = blk_last_q;

   md5_blk_buf u_buf (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .wr_en_i  (buf_wr),
      .idx_i    (idx_q),
      .wr_dat_i (in_data_i),
      .pad_en_i (buf_pad),
      .len_en_i (buf_len),
      .len_i    (len_w),
      .clr_i    (buf_clr),
      .blk_o    (blk_o)
   );

endmodule

// File: tb/tb_md5_padder.sv
// Bench for md5_padder: random messages against an RFC 1321 padding model, plus directed cases.
module tb_md5_padder;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [7:0]   in_data_i;
   logic         in_valid_i;
   logic         in_last_i;
   logic         in_ready_o;
   logic [511:0] blk_o;
   logic         blk_valid_o;
   logic         blk_last_o;
   logic         blk_ready_i;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_acc_cyc = 0;

   byte unsigned msg_q[$];
   logic [511:0] exp_blk_q[$];
   logic         exp_last_q[$];
   logic [511:0] got_blk_q[$];
   int           rise_cyc_q[$];

   md5_padder #(.W(32), .CNT_W(61)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_last_i   (in_last_i),
      .in_ready_o  (in_ready_o),
      .blk_o       (blk_o),
      .blk_valid_o (blk_valid_o),
      .blk_last_o  (blk_last_o),
      .blk_ready_i (blk_ready_i)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RFC 1321 padding done on a plain byte list, then cut into 64-byte blocks.
   task automatic build_exp();
      byte unsigned p[$];
      logic [63:0]  len;
      logic [511:0] blk;
      int           nblk;
      exp_blk_q.delete();
      exp_last_q.delete();
      p = msg_q;
      p.push_back(8'h80);
      while (p.size() % 64 != 56) p.push_back(8'h00);
      len = 64'(msg_q.size()) * 64'd8;
      for (int j = 0; j < 8; j++) p.push_back(len[8*j +: 8]);
      nblk = p.size() / 64;
      for (int b = 0; b < nblk; b++) begin
         blk = '0;
         for (int k = 0; k < 64; k++) blk[8*k +: 8] = p[64*b + k];
         exp_blk_q.push_back(blk);
         exp_last_q.push_back(b == nblk - 1);
      end
   endtask

   task automatic fill_const(input int n, input byte unsigned v);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(v);
   endtask

   task automatic fill_rand(input int n);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
   endtask

   task automatic send(input bit with_last, input int gap_max);
      int  gap;
      int  wait_n;
      bit  acc;
      for (int i = 0; i < msg_q.size(); i++) begin
         gap = $urandom_range(0, gap_max);
         in_valid_i = 1'b0;
         for (int g = 0; g < gap; g++) begin
            @(posedge clk_i); #1;
         end
         in_valid_i = 1'b1;
         in_data_i  = msg_q[i];
         in_last_i  = with_last && (i == msg_q.size() - 1);
         acc = 1'b0;
         wait_n = 0;
         while (!acc && wait_n < 2000) begin
            @(negedge clk_i);
            acc = in_ready_o;
            if (acc) last_acc_cyc = cyc;
            @(posedge clk_i); #1;
            wait_n++;
         end
         if (!acc) begin
            check("send_timeout", 512'(acc), 512'd1);
            break;
         end
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
   endtask

   // hold < 0: random ready; hold >= 0: ready held low for 'hold' valid cycles per block.
   task automatic recv(input int nblk, input int hold);
      logic [511:0] snap;
      logic         snap_last;
      int           held;
      int           n;
      bit           seen;
      bit           done;
      for (int b = 0; b < nblk; b++) begin
         seen = 1'b0;
         done = 1'b0;
         held = 0;
         n = 0;
         snap = '0;
         snap_last = 1'b0;
         while (!done && n < 3000) begin
            blk_ready_i = (hold < 0) ? 1'($urandom_range(0, 1)) : (held >= hold);
            @(negedge clk_i);
            if (blk_valid_o) begin
               if (!seen) begin
                  seen = 1'b1;
                  snap = blk_o;
                  snap_last = blk_last_o;
                  rise_cyc_q.push_back(cyc);
               end
               if (hold > 0) begin
                  check("hold_blk", blk_o, snap);
                  check("hold_last", 512'(blk_last_o), 512'(snap_last));
               end
               if (blk_ready_i) begin
                  got_blk_q.push_back(blk_o);
                  check("blk_avail", 512'(exp_blk_q.size() > 0), 512'd1);
                  if (exp_blk_q.size() > 0) begin
                     check("blk_dat", blk_o, exp_blk_q.pop_front());
                     check("blk_last", 512'(blk_last_o), 512'(exp_last_q.pop_front()));
                  end
                  done = 1'b1;
               end else begin
                  if (hold > 0) check("hold_in_rdy", 512'(in_ready_o), 512'd0);
                  held++;
               end
            end
            @(posedge clk_i); #1;
            n++;
         end
         if (!done) begin
            check("recv_timeout", 512'(done), 512'd1);
            break;
         end
      end
      if (hold > 0) begin
         @(negedge clk_i);
         check("post_in_rdy", 512'(in_ready_o), 512'd1);
         check("post_vld", 512'(blk_valid_o), 512'd0);
         @(posedge clk_i); #1;
      end
      blk_ready_i = 1'b0;
   endtask

   task automatic run_msg(input int gap_max, input int hold);
      int nblk;
      build_exp();
      got_blk_q.delete();
      rise_cyc_q.delete();
      nblk = exp_blk_q.size();
      fork
         send(1'b1, gap_max);
         recv(nblk, hold);
      join
      @(posedge clk_i); #1;
      check("blk_left", 512'(exp_blk_q.size()), 512'd0);
   endtask

   function automatic logic [31:0] word_of(input logic [511:0] blk, input int w);
      return blk[32*w +: 32];
   endfunction

   logic [511:0] abc_blk;
   logic [511:0] tmp;
   int           lens[12] = '{1, 54, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128};

   initial begin
      abc_blk = '0;
      abc_blk[31:0] = 32'h80636261;
      abc_blk[14*32 +: 32] = 32'h00000018;

      rst_i = 1'b0;
      in_data_i = 8'h00;
      in_valid_i = 1'b0;
      in_last_i = 1'b0;
      blk_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_vld", 512'(blk_valid_o), 512'd0);
      check("rst_last", 512'(blk_last_o), 512'd0);
      check("rst_blk", blk_o, 512'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(negedge clk_i);
      check("rst_in_rdy", 512'(in_ready_o), 512'd1);
      @(posedge clk_i); #1;

      // "abc", ready always high
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_msg(0, 0);
      check("abc_blk", got_blk_q[0], abc_blk);
      check("abc_lat", 512'(rise_cyc_q[0] - last_acc_cyc), 512'd2);

      fill_const(55, 8'h61);
      run_msg(0, 0);
      check("m55_w0", 512'(word_of(got_blk_q[0], 0)), 512'h61616161);
      check("m55_w13", 512'(word_of(got_blk_q[0], 13)), 512'h80616161);
      check("m55_w14", 512'(word_of(got_blk_q[0], 14)), 512'h000001b8);

      fill_const(56, 8'h61);
      run_msg(0, 0);
      check("m56_a_w14", 512'(word_of(got_blk_q[0], 14)), 512'h00000080);
      tmp = '0;
      tmp[14*32 +: 32] = 32'h000001c0;
      check("m56_b", got_blk_q[1], tmp);

      fill_const(64, 8'h61);
      run_msg(0, 0);
      check("m64_a", got_blk_q[0], {16{32'h61616161}});
      tmp = '0;
      tmp[31:0] = 32'h00000080;
      tmp[14*32 +: 32] = 32'h00000200;
      check("m64_b", got_blk_q[1], tmp);
      check("m64_lat", 512'(rise_cyc_q[0] - last_acc_cyc), 512'd1);

      // backpressure: ready low for 5 valid cycles
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_msg(0, 5);
      check("bp_abc_blk", got_blk_q[0], abc_blk);

      // reset after 20 bytes of an unfinished message
      fill_rand(20);
      send(1'b0, 1);
      rst_i = 1'b0;
      @(negedge clk_i);
      check("mid_rst_vld", 512'(blk_valid_o), 512'd0);
      check("mid_rst_blk", blk_o, 512'd0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      msg_q = '{8'h61, 8'h62, 8'h63};
      run_msg(0, 0);
      check("rst_abc_blk", got_blk_q[0], abc_blk);

      for (int i = 0; i < 12; i++) begin
         fill_rand(lens[i]);
         run_msg(2, -1);
      end
      for (int i = 0; i < 6; i++) begin
         fill_rand($urandom_range(1, 200));
         run_msg(3, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
